// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared constants and helpers for the S/PDIF transmitter
package spdif_pkg;

    // Preamble half-cell patterns, first half-cell in bit 7, for a line starting at 0.
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam int SLOTS_PER_SUBFRAME     = 32;
    localparam int HALFCELLS_PER_SUBFRAME = 64;
    localparam int FRAMES_PER_BLOCK       = 192;
    localparam int AUDIO_BITS             = 24;

    localparam logic [4:0] SLOT_AUDIO_LO = 5'd4;
    localparam logic [4:0] SLOT_AUDIO_HI = 5'd27;
    localparam logic [4:0] SLOT_V        = 5'd28;
    localparam logic [4:0] SLOT_U        = 5'd29;
    localparam logic [4:0] SLOT_C        = 5'd30;
    localparam logic [4:0] SLOT_P        = 5'd31;

    typedef enum logic {
        SUB_LEFT  = 1'b0,
        SUB_RIGHT = 1'b1
    } subframe_e;

    // Frame 0 left opens a block (B); other left subframes get M; right gets W.
    function automatic logic [7:0] preamble_sel(input subframe_e sub, input logic [7:0] frame);
        if (sub == SUB_RIGHT) begin
            return PRE_W;
        end
        return (frame == 8'd0) ? PRE_B : PRE_M;
    endfunction

endpackage

// File: rtl/spdif_bmc_encoder.sv
// rtl/spdif_bmc_encoder.sv - biphase-mark line register with preamble injection
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tick_i            half-cell strobe; line only moves on these cycles
//   pre_valid_i       current half-cell belongs to a preamble
//   pre_first_i       current half-cell is the first of a preamble
//   pre_bit_i         preamble pattern bit for this half-cell
//   data_bit_i        data bit of the current slot
//   second_half_i     0 = first half-cell of the slot, 1 = second
//   line_o            registered biphase-mark output
module spdif_bmc_encoder (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic pre_valid_i,
    input  logic pre_first_i,
    input  logic pre_bit_i,
    input  logic data_bit_i,
    input  logic second_half_i,
    output logic line_o
);

    logic line_q;
    logic base_q;    // line level captured just before the current preamble
    logic base_now;

    // On the first preamble half-cell the reference is the live line level.
    assign base_now = pre_first_i ? line_q : base_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= 1'b0;
            base_q <= 1'b0;
        end else if (tick_i) begin
            if (pre_valid_i) begin
                line_q <= pre_bit_i ^ base_now;
                if (pre_first_i) begin
                    base_q <= line_q;
                end
            end else if (!second_half_i) begin
                line_q <= ~line_q;
            end else begin
                line_q <= line_q ^ data_bit_i;
            end
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/spdif_transmit.sv
// rtl/spdif_transmit.sv - IEC 60958 consumer transmitter fed from a sample holding register
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   tick                       half-cell strobe at 128*fs
//   data_left, data_right      MSB-justified 32-bit samples
//   data_valid                 writes the holding register and marks it fresh
//   spdif_out                  biphase-mark line
//   frame_start, block_start   pulses aligned with the first preamble half-cell
//   underrun                   pulse when a frame load finds no fresh sample
module spdif_transmit
    import spdif_pkg::*;
#(
    parameter int          SAMPLE_W = 24,
    parameter logic [31:0] CS_WORD  = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [31:0] data_left,
    input  logic [31:0] data_right,
    input  logic        data_valid,
    output logic        spdif_out,
    output logic        frame_start,
    output logic        block_start,
    output logic        underrun
);

    logic [5:0]            hc_q;
    subframe_e             sub_q;
    logic [7:0]            frame_q;
    logic [AUDIO_BITS-1:0] hold_l_q, hold_r_q;
    logic [AUDIO_BITS-1:0] sh_l_q, sh_r_q;
    logic                  fresh_q;
    logic                  par_q;
    logic                  frame_start_q, block_start_q, underrun_q;

    logic [4:0]            slot;
    logic                  in_pre;
    logic                  frame_load;
    logic                  audio_slot;
    logic [7:0]            pre_pat;
    logic                  pre_bit;
    logic                  c_bit;
    logic                  data_bit;
    logic [AUDIO_BITS-1:0] samp_l, samp_r;
    logic                  unused_lsbs;

    assign slot       = hc_q[5:1];
    assign in_pre     = (slot < SLOT_AUDIO_LO);
    assign frame_load = tick && (hc_q == 6'd0) && (sub_q == SUB_LEFT);
    assign audio_slot = (slot >= SLOT_AUDIO_LO) && (slot <= SLOT_AUDIO_HI);
    assign pre_pat    = preamble_sel(sub_q, frame_q);
    assign pre_bit    = pre_pat[3'd7 - hc_q[2:0]];
    assign c_bit      = (frame_q < 8'd32) ? CS_WORD[frame_q[4:0]] : 1'b0;

    // Sample sits in the top SAMPLE_W bits of the 24-bit audio field.
    assign samp_l = AUDIO_BITS'(data_left[31:32-SAMPLE_W]) << (AUDIO_BITS - SAMPLE_W);
    assign samp_r = AUDIO_BITS'(data_right[31:32-SAMPLE_W]) << (AUDIO_BITS - SAMPLE_W);
    assign unused_lsbs = ^{data_left[31-SAMPLE_W:0], data_right[31-SAMPLE_W:0]};

    always_comb begin
        data_bit = 1'b0;
        if (audio_slot) begin
            data_bit = (sub_q == SUB_RIGHT) ? sh_r_q[0] : sh_l_q[0];
        end else if (slot == SLOT_C) begin
            data_bit = c_bit;
        end else if (slot == SLOT_P) begin
            data_bit = par_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q          <= '0;
            sub_q         <= SUB_LEFT;
            frame_q       <= '0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            sh_l_q        <= '0;
            sh_r_q        <= '0;
            fresh_q       <= 1'b0;
            par_q         <= 1'b0;
            frame_start_q <= 1'b0;
            block_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            block_start_q <= 1'b0;
            underrun_q    <= 1'b0;

            // A write coinciding with a load lands after the load reads the old value.
            if (data_valid) begin
                hold_l_q <= samp_l;
                hold_r_q <= samp_r;
            end
            if (data_valid) begin
                fresh_q <= 1'b1;
            end else if (frame_load) begin
                fresh_q <= 1'b0;
            end

            if (tick) begin
                if (frame_load) begin
                    sh_l_q        <= hold_l_q;
                    sh_r_q        <= hold_r_q;
                    underrun_q    <= ~fresh_q;
                    frame_start_q <= 1'b1;
                    block_start_q <= (frame_q == 8'd0);
                end else if (audio_slot && hc_q[0]) begin
                    if (sub_q == SUB_RIGHT) begin
                        sh_r_q <= sh_r_q >> 1;
                    end else begin
                        sh_l_q <= sh_l_q >> 1;
                    end
                end

                // Parity accumulates slots 4..30 and is emitted in slot 31.
                if (in_pre) begin
                    par_q <= 1'b0;
                end else if (hc_q[0] && (slot <= SLOT_C)) begin
                    par_q <= par_q ^ data_bit;
                end

                hc_q <= hc_q + 6'd1;
                if (hc_q == 6'(HALFCELLS_PER_SUBFRAME - 1)) begin
                    sub_q <= (sub_q == SUB_LEFT) ? SUB_RIGHT : SUB_LEFT;
                    if (sub_q == SUB_RIGHT) begin
                        frame_q <= (frame_q == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_q + 8'd1;
                    end
                end
            end
        end
    end

    spdif_bmc_encoder u_bmc (
        .clk          (clk),
        .rst          (rst),
        .tick_i       (tick),
        .pre_valid_i  (in_pre),
        .pre_first_i  (hc_q == 6'd0),
        .pre_bit_i    (pre_bit),
        .data_bit_i   (data_bit),
        .second_half_i(hc_q[0]),
        .line_o       (spdif_out)
    );

    assign frame_start = frame_start_q;
    assign block_start = block_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spdif_transmit.sv
// tb/tb_spdif_transmit.sv - directed self-checking bench for spdif_transmit
module tb_spdif_transmit;

    localparam logic [7:0] B_PAT = 8'b1110_1000;
    localparam logic [7:0] M_PAT = 8'b1110_0010;
    localparam logic [7:0] W_PAT = 8'b1110_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [31:0] data_left = '0;
    logic [31:0] data_right = '0;
    logic        data_valid = 1'b0;
    logic        spdif_out, frame_start, block_start, underrun;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spdif_transmit #(.SAMPLE_W(24), .CS_WORD(32'h0000_0004)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .data_left  (data_left),
        .data_right (data_right),
        .data_valid (data_valid),
        .spdif_out  (spdif_out),
        .frame_start(frame_start),
        .block_start(block_start),
        .underrun   (underrun)
    );

    // Expected 64 half-cells of one subframe, index = half-cell number, line starting at 0.
    function automatic logic [63:0] model_sf(input logic [7:0] pre, input logic [23:0] s, input logic c);
        logic [31:0] b;
        logic [63:0] r;
        logic        lvl;
        b = '0;
        b[27:4] = s;
        b[30] = c;
        b[31] = ^{s, c};
        r = '0;
        for (int h = 0; h < 8; h++) r[h] = pre[7-h];
        lvl = 1'b0;
        for (int sl = 4; sl < 32; sl++) begin
            lvl = ~lvl;
            r[2*sl] = lvl;
            if (b[sl]) lvl = ~lvl;
            r[2*sl+1] = lvl;
        end
        return r;
    endfunction

    function automatic logic decode_slot(input logic [63:0] r, input int sl);
        return r[2*sl] != r[2*sl+1];
    endfunction

    function automatic logic [23:0] decode_audio(input logic [63:0] r);
        logic [23:0] a;
        for (int i = 0; i < 24; i++) a[i] = decode_slot(r, 4 + i);
        return a;
    endfunction

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
    endtask

    task automatic run_frame(input bit dv0, input logic [31:0] l, input logic [31:0] r,
                             output logic [63:0] lf, output logic [63:0] rf,
                             output int fs, output int bs, output int ur);
        fs = 0; bs = 0; ur = 0; lf = '0; rf = '0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            tick = 1'b1;
            if (i == 0 && dv0) begin
                data_valid = 1'b1; data_left = l; data_right = r;
            end
            @(posedge clk); #1;
            if (i < 64) lf[i] = spdif_out; else rf[i-64] = spdif_out;
            fs += int'(frame_start); bs += int'(block_start); ur += int'(underrun);
            @(negedge clk);
            tick = 1'b0; data_valid = 1'b0;
        end
    endtask

    task automatic send_data(input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        data_valid = 1'b1; data_left = l; data_right = r;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (spdif_out !== 1'b0) begin bad++; $display("FAIL reset_line got=%b exp=0", spdif_out); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        total++; if (block_start !== 1'b0) begin bad++; $display("FAIL reset_bs got=%b exp=0", block_start); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_ur got=%b exp=0", underrun); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_idle;
        logic [63:0] lf, rf, e;
        int fs, bs, ur;
        run_frame(0, '0, '0, lf, rf, fs, bs, ur);
        e = model_sf(B_PAT, 24'h0, 1'b0);
        total++; if (lf !== e) begin bad++; $display("FAIL idle_f0_left got=%h exp=%h", lf, e); end
        total++; if (lf[7:0] !== 8'b0001_0111) begin bad++; $display("FAIL idle_B_pre got=%b exp=00010111 (hc7..hc0)", lf[7:0]); end
        e = model_sf(W_PAT, 24'h0, 1'b0);
        total++; if (rf !== e) begin bad++; $display("FAIL idle_f0_right got=%h exp=%h", rf, e); end
        total++; if (fs !== 1 || bs !== 1 || ur !== 1) begin bad++; $display("FAIL idle_f0_pulses got fs=%0d bs=%0d ur=%0d exp 1 1 1", fs, bs, ur); end
        run_frame(0, '0, '0, lf, rf, fs, bs, ur);
        e = model_sf(M_PAT, 24'h0, 1'b0);
        total++; if (lf !== e) begin bad++; $display("FAIL idle_f1_left got=%h exp=%h", lf, e); end
        total++; if (fs !== 1 || bs !== 0 || ur !== 1) begin bad++; $display("FAIL idle_f1_pulses got fs=%0d bs=%0d ur=%0d exp 1 0 1", fs, bs, ur); end
        run_frame(0, '0, '0, lf, rf, fs, bs, ur);
        e = model_sf(M_PAT, 24'h0, 1'b1);
        total++; if (lf !== e) begin bad++; $display("FAIL idle_f2_left_c got=%h exp=%h", lf, e); end
        e = model_sf(W_PAT, 24'h0, 1'b1);
        total++; if (rf !== e) begin bad++; $display("FAIL idle_f2_right_c got=%h exp=%h", rf, e); end
        total++; if (decode_slot(lf, 30) !== 1'b1 || decode_slot(lf, 31) !== 1'b1) begin
            bad++; $display("FAIL idle_f2_cp got c=%b p=%b exp c=1 p=1", decode_slot(lf, 30), decode_slot(lf, 31));
        end
    endtask

    task automatic test_data_frame0;
        logic [63:0] lf, rf, e;
        int fs, bs, ur;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        send_data(32'h1234_5600, 32'h0000_0000);
        run_frame(0, '0, '0, lf, rf, fs, bs, ur);
        total++; if (decode_audio(lf) !== 24'h123456) begin bad++; $display("FAIL data_audio got=%h exp=123456", decode_audio(lf)); end
        total++; if (decode_slot(lf, 31) !== 1'b1) begin bad++; $display("FAIL data_parity_l got=%b exp=1", decode_slot(lf, 31)); end
        e = model_sf(B_PAT, 24'h123456, 1'b0);
        total++; if (lf !== e) begin bad++; $display("FAIL data_left got=%h exp=%h", lf, e); end
        e = model_sf(W_PAT, 24'h0, 1'b0);
        total++; if (rf !== e) begin bad++; $display("FAIL data_right got=%h exp=%h", rf, e); end
        total++; if (decode_slot(rf, 31) !== 1'b0) begin bad++; $display("FAIL data_parity_r got=%b exp=0", decode_slot(rf, 31)); end
        total++; if (ur !== 0 || bs !== 1) begin bad++; $display("FAIL data_pulses got ur=%0d bs=%0d exp 0 1", ur, bs); end
    endtask

    task automatic test_coincident;
        logic [63:0] lf, rf, e;
        int fs, bs, ur;
        run_frame(1, 32'hFFFF_FF00, 32'h0000_0000, lf, rf, fs, bs, ur);
        e = model_sf(M_PAT, 24'h123456, 1'b0);
        total++; if (lf !== e) begin bad++; $display("FAIL coin_resend got=%h exp=%h", lf, e); end
        total++; if (ur !== 1) begin bad++; $display("FAIL coin_ur_load got=%0d exp=1", ur); end
        run_frame(0, '0, '0, lf, rf, fs, bs, ur);
        e = model_sf(M_PAT, 24'hFFFFFF, 1'b1);
        total++; if (lf !== e) begin bad++; $display("FAIL coin_next got=%h exp=%h", lf, e); end
        total++; if (decode_audio(lf) !== 24'hFFFFFF) begin bad++; $display("FAIL coin_audio got=%h exp=ffffff", decode_audio(lf)); end
        total++; if (ur !== 0) begin bad++; $display("FAIL coin_ur_next got=%0d exp=0", ur); end
    endtask

    task automatic test_full_block;
        logic [63:0] lf, rf, e;
        int fs, bs, ur, fs_sum, bs_sum, ur_sum;
        fs_sum = 0; bs_sum = 0; ur_sum = 0;
        for (int f = 3; f < 192; f++) begin
            run_frame(0, '0, '0, lf, rf, fs, bs, ur);
            fs_sum += fs; bs_sum += bs; ur_sum += ur;
        end
        e = model_sf(M_PAT, 24'hFFFFFF, 1'b0);
        total++; if (lf !== e) begin bad++; $display("FAIL blk_f191 got=%h exp=%h", lf, e); end
        total++; if (fs_sum !== 189 || bs_sum !== 0 || ur_sum !== 189) begin
            bad++; $display("FAIL blk_counts got fs=%0d bs=%0d ur=%0d exp 189 0 189", fs_sum, bs_sum, ur_sum);
        end
        run_frame(0, '0, '0, lf, rf, fs, bs, ur);
        e = model_sf(B_PAT, 24'hFFFFFF, 1'b0);
        total++; if (lf !== e) begin bad++; $display("FAIL blk_wrap_B got=%h exp=%h", lf, e); end
        total++; if (bs !== 1 || fs !== 1) begin bad++; $display("FAIL blk_wrap_pulses got bs=%0d fs=%0d exp 1 1", bs, fs); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] lf, rf, e;
        int fs, bs, ur;
        e = model_sf(M_PAT, 24'hFFFFFF, 1'b0);
        run_ticks(37);
        #1;
        total++; if (spdif_out !== e[36]) begin bad++; $display("FAIL mid_pre_level got=%b exp=%b", spdif_out, e[36]); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++; if (spdif_out !== 1'b0) begin bad++; $display("FAIL mid_rst_line got=%b exp=0", spdif_out); end
        @(negedge clk); rst = 1'b0;
        run_frame(0, '0, '0, lf, rf, fs, bs, ur);
        e = model_sf(B_PAT, 24'h0, 1'b0);
        total++; if (lf !== e) begin bad++; $display("FAIL mid_restart got=%h exp=%h", lf, e); end
        total++; if (bs !== 1 || ur !== 1) begin bad++; $display("FAIL mid_restart_pulses got bs=%0d ur=%0d exp 1 1", bs, ur); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_data_frame0();
        test_coincident();
        test_full_block();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
